spi_xfer_queue: RTL and testbench
=================================

SPI_XFER_QUEUE -- requirements
Module: spi_xfer_queue

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: SPI word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: entries per TX and RX FIFO; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port wr_en, input, 1: push wr_data into the TX FIFO.
REQ-006 SHALL have port wr_data, input, DWIDTH: word to transmit.
REQ-007 SHALL have port full, output, 1: TX FIFO holds DEPTH words.
REQ-008 SHALL have port tx_count, output, log2(DEPTH)+1: TX FIFO occupancy.
REQ-009 SHALL have port rd_en, input, 1: pop the RX FIFO.
REQ-010 SHALL have port rd_data, output, DWIDTH: RX FIFO head word, valid while rx_valid=1.
REQ-011 SHALL have port rx_valid, output, 1: RX FIFO not empty.
REQ-012 SHALL have port m_start, output, 1: start pulse to the SPI master.
REQ-013 SHALL have port m_mosi_data, output, DWIDTH: word presented to the SPI master.
REQ-014 SHALL have port m_busy, input, 1: SPI master busy.
REQ-015 SHALL have port m_miso_data, input, DWIDTH: word received by the SPI master.
REQ-016 SHALL have port xfer_active, output, 1: FSM is not in IDLE.
REQ-017 SHALL have port err, output, 1: sticky transfer-timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, STORE.
REQ-019 SHALL move IDLE->LAUNCH when the TX FIFO is non-empty, the RX FIFO is not full, and m_busy=0.
REQ-020 SHALL, in LAUNCH, drive m_start=1 for exactly one cycle, pop the TX head into a register driving m_mosi_data, then go to WAIT_BUSY.
REQ-021 SHALL hold m_mosi_data stable from LAUNCH until the next LAUNCH.
REQ-022 SHALL move WAIT_BUSY->WAIT_DONE on m_busy=1, and WAIT_DONE->STORE on m_busy=0.
REQ-023 SHALL, in STORE, push m_miso_data into the RX FIFO and return to IDLE, so back-to-back launches are at least 1 idle cycle apart.
REQ-024 SHALL ignore a push while full=1 and a pop while rx_valid=0; neither changes FIFO state.
REQ-025 SHALL, on a push coinciding with a LAUNCH pop, perform both and leave tx_count unchanged.
REQ-026 SHALL, on a pop coinciding with a STORE push, perform both; pointers wrap modulo DEPTH.
REQ-027 SHALL present rd_data combinationally from the RX head, with 0-cycle read latency.
REQ-028 SHALL never launch while the RX FIFO is full; this is RX backpressure, and no received word is lost.

Reset
REQ-029 SHALL, when reset=0 at a clk edge, enter IDLE and empty both FIFOs.
REQ-030 SHALL reset outputs to: m_start=0, m_mosi_data=0, full=0, tx_count=0, rx_valid=0, xfer_active=0, err=0.
REQ-031 SHALL, on reset mid-transfer, abandon the in-flight word without storing it.

Configuration
REQ-032 SHALL compile the watchdog logic in only when macro SPI_XFER_QUEUE_TIMEOUT_EN is defined.
REQ-033 SHALL, with the macro defined, count cycles in WAIT_BUSY and WAIT_DONE; if the count reaches 255, set err=1, push nothing, and go to IDLE.
REQ-034 SHALL clear err only by reset.
REQ-035 SHALL, without the macro, wait indefinitely in WAIT_BUSY and WAIT_DONE, with err tied to 0.

Verification
REQ-036 SHALL verify single word: push 8'hC5, master model busy for 10 cycles returning 8'h5A -> one m_start pulse, m_mosi_data=8'hC5, then rx_valid=1 and rd_data=8'h5A.
REQ-037 SHALL verify TX full: push 5 words (8'h01..8'h05) with m_busy held 1 -> full=1 after 4 pushes, 8'h05 dropped, tx_count=4, m_start stays 0.
REQ-038 SHALL verify RX backpressure: 5 transfers with rd_en=0 -> exactly 4 m_start pulses; after one rd_en, the fifth launches.
REQ-039 SHALL verify simultaneity: wr_en in the LAUNCH cycle -> tx_count unchanged; rd_en in the STORE cycle -> rx_valid stays 1.
REQ-040 SHALL verify reset mid-transfer: reset=0 during WAIT_DONE -> next cycle all outputs are at reset values and the RX FIFO is empty.
REQ-041 SHALL verify timeout (macro defined): m_busy never rises after m_start -> err=1 after 255 cycles, FSM in IDLE, rx_valid=0.

Source files
------------

// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: TX/RX word FIFOs wrapped around a start/busy SPI master handshake.
// Define SPI_XFER_QUEUE_TIMEOUT_EN to build the transfer watchdog and its sticky err flag.

module spi_xfer_queue_fifo #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [DWIDTH-1:0]      push_data,
   input  logic                   pop,
   output logic [DWIDTH-1:0]      head,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              do_push, do_pop;

   // Overflowing pushes and underflowing pops are dropped without side effects.
   assign do_push = push && (count != (AW+1)'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

module spi_xfer_queue #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [DWIDTH-1:0]      wr_data,
   output logic                   full,
   output logic [$clog2(DEPTH):0] tx_count,
   input  logic                   rd_en,
   output logic [DWIDTH-1:0]      rd_data,
   output logic                   rx_valid,
   output logic                   m_start,
   output logic [DWIDTH-1:0]      m_mosi_data,
   input  logic                   m_busy,
   input  logic [DWIDTH-1:0]      m_miso_data,
   output logic                   xfer_active,
   output logic                   err
);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int TXQ = 0;
   localparam int RXQ = 1;

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, STORE} state_t;

   state_t                 state, state_nxt;
   logic [1:0]             q_push, q_pop;
   logic [1:0][DWIDTH-1:0] q_wdata, q_head;
   logic [1:0][CW-1:0]     q_count;
   logic                   tx_pop, rx_push, mosi_load, rx_full, timeout;
   logic [DWIDTH-1:0]      mosi_q;

   assign q_push[TXQ]  = wr_en;
   assign q_wdata[TXQ] = wr_data;
   assign q_pop[TXQ]   = tx_pop;
   assign q_push[RXQ]  = rx_push;
   assign q_wdata[RXQ] = m_miso_data;
   assign q_pop[RXQ]   = rd_en;

   for (genvar g = 0; g < 2; g++) begin : g_q
      spi_xfer_queue_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push      (q_push[g]),
         .push_data (q_wdata[g]),
         .pop       (q_pop[g]),
         .head      (q_head[g]),
         .count     (q_count[g])
      );
   end

   assign tx_count    = q_count[TXQ];
   assign full        = (q_count[TXQ] == CW'(DEPTH));
   assign rx_full     = (q_count[RXQ] == CW'(DEPTH));
   assign rx_valid    = (q_count[RXQ] != '0);
   assign rd_data     = q_head[RXQ];
   assign m_start     = (state == LAUNCH);
   assign xfer_active = (state != IDLE);
   assign m_mosi_data = mosi_q;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Launch needs a free RX slot so the reply always has somewhere to land.
   always_comb begin
      state_nxt = state;
      tx_pop    = 1'b0;
      rx_push   = 1'b0;
      mosi_load = 1'b0;
      case (state)
         IDLE: begin
            if ((q_count[TXQ] != '0) && !rx_full && !m_busy) begin
               state_nxt = LAUNCH;
               mosi_load = 1'b1;
            end
         end
         LAUNCH: begin
            tx_pop    = 1'b1;
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (timeout)     state_nxt = IDLE;
            else if (m_busy) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (timeout)      state_nxt = IDLE;
            else if (!m_busy) state_nxt = STORE;
         end
         STORE: begin
            rx_push   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Captured on entry to LAUNCH so the word is already valid alongside m_start.
   always_ff @(posedge clk) begin
      if (!reset)         mosi_q <= '0;
      else if (mosi_load) mosi_q <= q_head[TXQ];
   end

`ifdef SPI_XFER_QUEUE_TIMEOUT_EN
   logic [7:0] wd_cnt;
   logic       err_q;
   logic       in_wait;

   assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);
   // wd_cnt reads 0 on the first wait cycle, so 254 marks the 255th.
   assign timeout = in_wait && (wd_cnt == 8'd254);
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         wd_cnt <= in_wait ? wd_cnt + 8'd1 : 8'd0;
         if (timeout) err_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_spi_xfer_queue.sv
// Directed bench for spi_xfer_queue: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.

module tb_spi_xfer_queue;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 3;
`ifdef SPI_XFER_QUEUE_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif
   localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_WB = 2, PH_WD = 3, PH_STORE = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en, rd_en, full, rx_valid, m_start, m_busy, xfer_active, err;
   logic [DW-1:0] wr_data, rd_data, m_mosi_data, m_miso_data;
   logic [CW-1:0] tx_count;

   int checks   = 0;
   int failures = 0;
   int n_start  = 0;

   // master-model controls
   bit            hold_busy = 1'b0;
   bit            resp_en   = 1'b1;
   int            busy_len  = 3;
   logic [DW-1:0] replies[$];

   // reference model
   logic [DW-1:0] tx_q[$], rx_q[$];
   logic [DW-1:0] mdl_mosi;
   int            ph, wn;
   bit            mdl_err;

   spi_xfer_queue #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full),
      .tx_count    (tx_count),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rx_valid    (rx_valid),
      .m_start     (m_start),
      .m_mosi_data (m_mosi_data),
      .m_busy      (m_busy),
      .m_miso_data (m_miso_data),
      .xfer_active (xfer_active),
      .err         (err)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance the model across one rising edge using the inputs present at that edge.
   task automatic model_edge();
      int tx_n, rx_n;
      bit tx_push;
      tx_n = tx_q.size();
      rx_n = rx_q.size();
      if (!reset) begin
         tx_q.delete();
         rx_q.delete();
         ph = PH_IDLE; wn = 0; mdl_mosi = '0; mdl_err = 1'b0;
         return;
      end
      tx_push = wr_en && (tx_n < DEPTH);
      if (rd_en && rx_n > 0) void'(rx_q.pop_front());
      case (ph)
         PH_IDLE: if (tx_n > 0 && rx_n < DEPTH && !m_busy) begin
            ph = PH_LAUNCH;
            mdl_mosi = tx_q[0];
         end
         PH_LAUNCH: begin
            void'(tx_q.pop_front());
            ph = PH_WB;
            wn = 0;
         end
         PH_WB, PH_WD: begin
            wn++;
            if (TMO && wn == 255) begin mdl_err = 1'b1; ph = PH_IDLE; end
            else if (ph == PH_WB && m_busy)  ph = PH_WD;
            else if (ph == PH_WD && !m_busy) ph = PH_STORE;
         end
         PH_STORE: begin
            rx_q.push_back(m_miso_data);
            ph = PH_IDLE;
         end
         default: ph = PH_IDLE;
      endcase
      if (tx_push) tx_q.push_back(wr_data);
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         chk("mon_m_start", m_start, ph == PH_LAUNCH);
         chk("mon_xfer_active", xfer_active, ph != PH_IDLE);
         chk("mon_m_mosi_data", m_mosi_data, mdl_mosi);
         chk("mon_tx_count", tx_count, tx_q.size());
         chk("mon_full", full, tx_q.size() == DEPTH);
         chk("mon_rx_valid", rx_valid, rx_q.size() > 0);
         chk("mon_err", err, mdl_err);
         if (rx_q.size() > 0) chk("mon_rd_data", rd_data, rx_q[0]);
      end
   end

   initial begin : start_counter
      forever begin
         @(negedge clk);
         if (m_start === 1'b1) n_start++;
      end
   end

   // SPI master stand-in: after seeing m_start, busy for busy_len cycles and return a reply.
   initial begin : master
      logic st, rs;
      int   cnt;
      cnt = 0;
      m_busy = 1'b0;
      m_miso_data = '0;
      forever begin
         @(negedge clk);
         st = m_start;
         rs = reset;
         @(posedge clk);
         #1;
         if (!rs) cnt = 0;
         else if (st === 1'b1 && resp_en) begin
            cnt = busy_len;
            if (replies.size() > 0) m_miso_data = replies.pop_front();
         end
         if (hold_busy) m_busy = 1'b1;
         else if (cnt > 0) begin m_busy = 1'b1; cnt--; end
         else m_busy = 1'b0;
      end
   end

   initial begin : guard
      #500000;
      $display("FAIL tb_timeout: simulation did not finish, failures=%0d", failures);
      $fatal(1, "bench time limit");
   end

   initial begin : main
      bit            ok;
      int            s0, k;
      logic [DW-1:0] exp3 [4];
      exp3 = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
      reset = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_m_start", m_start, 0);
      chk("rst_m_mosi_data", m_mosi_data, 0);
      chk("rst_full", full, 0);
      chk("rst_tx_count", tx_count, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_xfer_active", xfer_active, 0);
      chk("rst_err", err, 0);
      step(); reset = 1'b1;
      step();

      // single word
      busy_len = 10; replies.push_back(8'h5A);
      s0 = n_start;
      wr_data = 8'hC5; wr_en = 1'b1; step(); wr_en = 1'b0;
      ok = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (m_start) begin ok = 1; break; end end
      chk("t1_launch_seen", ok, 1);
      chk("t1_mosi", m_mosi_data, 8'hC5);
      ok = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (rx_valid) begin ok = 1; break; end end
      chk("t1_rx_valid", ok, 1);
      chk("t1_rd_data", rd_data, 8'h5A);
      chk("t1_one_start", n_start - s0, 1);
      chk("t1_mosi_held", m_mosi_data, 8'hC5);
      step(); rd_en = 1'b1; step(); rd_en = 1'b0;
      @(negedge clk);
      chk("t1_rx_drained", rx_valid, 0);

      // TX full while the master holds busy
      hold_busy = 1'b1; step();
      s0 = n_start;
      for (int i = 1; i <= 5; i++) begin
         wr_data = 8'(i); wr_en = 1'b1; step();
         if (i == 3) begin @(negedge clk); chk("t2_not_full_at3", full, 0); end
         if (i == 4) begin @(negedge clk); chk("t2_full_at4", full, 1); end
      end
      wr_en = 1'b0;
      @(negedge clk);
      chk("t2_tx_count", tx_count, 4);
      chk("t2_full", full, 1);
      repeat (5) step();
      chk("t2_no_start", n_start - s0, 0);

      // RX backpressure: five transfers, nothing read
      for (int i = 1; i <= 5; i++) replies.push_back(8'hA0 + 8'(i));
      busy_len = 3; hold_busy = 1'b0;
      ok = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (!full) begin ok = 1; break; end end
      chk("t3_tx_room", ok, 1);
      wr_data = 8'h06; wr_en = 1'b1; step(); wr_en = 1'b0;
      repeat (150) step();
      chk("t3_four_starts", n_start - s0, 4);
      chk("t3_tx_left", tx_count, 1);
      chk("t3_rx_valid", rx_valid, 1);
      chk("t3_head", rd_data, 8'hA1);
      rd_en = 1'b1; step(); rd_en = 1'b0;
      ok = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (n_start - s0 == 5) begin ok = 1; break; end end
      chk("t3_fifth_start", ok, 1);
      repeat (40) step();
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t3_drain", rd_data, exp3[i]);
         step();
      end
      rd_en = 1'b0;
      @(negedge clk);
      chk("t3_drained", rx_valid, 0);

      // simultaneous push/pop on LAUNCH and STORE
      busy_len = 2; replies.push_back(8'h77); replies.push_back(8'h88);
      wr_data = 8'h10; wr_en = 1'b1; step(); wr_en = 1'b0;
      ok = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (m_start) begin ok = 1; break; end end
      chk("t4_launch1", ok, 1);
      chk("t4_count_in_launch", tx_count, 1);
      wr_data = 8'h20; wr_en = 1'b1; step(); wr_en = 1'b0;
      @(negedge clk);
      chk("t4_tx_unchanged", tx_count, 1);
      ok = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (m_start) begin ok = 1; break; end end
      chk("t4_launch2", ok, 1);
      chk("t4_mosi2", m_mosi_data, 8'h20);
      ok = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (m_busy) begin ok = 1; break; end end
      chk("t4_busy_high", ok, 1);
      ok = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (!m_busy) begin ok = 1; break; end end
      chk("t4_busy_low", ok, 1);
      step(); rd_en = 1'b1;
      @(negedge clk);
      chk("t4_store_active", xfer_active, 1);
      chk("t4_store_head", rd_data, 8'h77);
      step(); rd_en = 1'b0;
      @(negedge clk);
      chk("t4_rx_valid_kept", rx_valid, 1);
      chk("t4_new_head", rd_data, 8'h88);
      rd_en = 1'b1; step(); rd_en = 1'b0;
      @(negedge clk);
      chk("t4_drained", rx_valid, 0);

      // reset during WAIT_DONE
      busy_len = 20; replies.push_back(8'h99);
      wr_data = 8'h33; wr_en = 1'b1; step(); wr_en = 1'b0;
      ok = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (m_start) begin ok = 1; break; end end
      chk("t5_launch", ok, 1);
      repeat (4) @(negedge clk);
      chk("t5_in_xfer", xfer_active, 1);
      step(); reset = 1'b0; step(); reset = 1'b1;
      @(negedge clk);
      chk("t5_m_start", m_start, 0);
      chk("t5_m_mosi_data", m_mosi_data, 0);
      chk("t5_full", full, 0);
      chk("t5_tx_count", tx_count, 0);
      chk("t5_rx_valid", rx_valid, 0);
      chk("t5_xfer_active", xfer_active, 0);
      chk("t5_err", err, 0);
      repeat (40) step();
      chk("t5_word_abandoned", rx_valid, 0);

      // master never responds
      resp_en = 1'b0;
      wr_data = 8'h44; wr_en = 1'b1; step(); wr_en = 1'b0;
      ok = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (m_start) begin ok = 1; break; end end
      chk("t6_launch", ok, 1);
`ifdef SPI_XFER_QUEUE_TIMEOUT_EN
      ok = 0; k = 0;
      for (int i = 1; i <= 300; i++) begin @(negedge clk); if (err) begin k = i; ok = 1; break; end end
      chk("t6_err_set", ok, 1);
      chk("t6_err_latency", k, 256);
      chk("t6_idle", xfer_active, 0);
      chk("t6_rx_empty", rx_valid, 0);
      chk("t6_tx_empty", tx_count, 0);
      repeat (5) step();
      chk("t6_err_sticky", err, 1);
`else
      k = 0;
      repeat (300) @(negedge clk);
      chk("t6_still_waiting", xfer_active, 1);
      chk("t6_err_tied", err, 0);
      chk("t6_rx_empty", rx_valid, 0);
`endif
      step(); reset = 1'b0; step(); reset = 1'b1;
      @(negedge clk);
      chk("t6_err_cleared", err, 0);
      chk("t6_idle_after_reset", xfer_active, 0);
      resp_en = 1'b1;
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
